// File: rtl/base_initarb.sv
// Write-port owner for an initialised table: sweeps every entry to INITV,
// then passes functional writes through a single registered output stage.
module base_initarb #(
  parameter int unsigned LOG_COUNT = 1,
  parameter int unsigned COUNT     = 2 ** LOG_COUNT,
  parameter int unsigned width     = 1,
  parameter logic [width-1:0] INITV = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [0:LOG_COUNT-1] i_a,
  input  logic [0:width-1]     i_d,
  input  logic                 i_reinit,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:LOG_COUNT-1] o_a,
  output logic [0:width-1]     o_d,
  output logic                 o_init_done
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LAST = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [LOG_COUNT-1:0] CNT_TOP = LOG_COUNT'(COUNT - 1);

  state_t                 state_q, state_d;
  logic [LOG_COUNT-1:0]   cnt_q, cnt_d;
  logic                   ov_q, ov_d;
  logic [0:LOG_COUNT-1]   oa_q, oa_d;
  logic [0:width-1]       od_q, od_d;
  logic                   ld;

  assign ld = ~ov_q | o_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= CNT_TOP;
      ov_q    <= 1'b0;
      oa_q    <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      oa_q    <= oa_d;
      od_q    <= od_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    oa_d    = oa_q;
    od_d    = od_q;
    i_r     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (ld) begin
          ov_d = 1'b1;
          oa_d = cnt_q;
          od_d = INITV;
          if (cnt_q == '0) state_d = ST_LAST;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_LAST: begin
        // o_v is always set here, so ld means the address-0 beat was taken
        if (ld) begin
          ov_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        i_r = ld;
        if (ld) begin
          ov_d = i_v;
          if (i_v) begin
            oa_d = i_a;
            od_d = i_d;
          end
        end
        if (i_reinit) begin
          state_d = ST_INIT;
          cnt_d   = CNT_TOP;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = CNT_TOP;
      end
    endcase
  end

  assign o_v         = ov_q;
  assign o_a         = oa_q;
  assign o_d         = od_q;
  assign o_init_done = (state_q == ST_RUN);

endmodule
